lsu_trigger_seq: RTL and testbench

Parametrised successor to the LSU debug-trigger matcher. It compares each dc3 load/store access against NTRIG trigger channels and supports four match modes (exact, NAPOT, >=, <). It adds stateful features: trigger chaining, where one trigger arms the next, and per-channel hit-count thresholds. Results are registered and delivered to dec in dc4.

---
 rtl/lsu_trigger_seq.sv | 137 +++++++++++++
 tb/tb_lsu_trigger_seq.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_trigger_seq.sv
// lsu_trigger_seq: LSU debug-trigger matcher with chaining and hit-count thresholds.
// Each dc3 load/store access is compared against NTRIG channels. A chaining
// channel arms its successor, and a counting channel fires only after a
// programmable number of qualified hits. Fires are registered into dc4.
module lsu_trigger_seq #(
  parameter int NTRIG = 4,
  parameter int DW    = 32,
  parameter int CW    = 4
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic [NTRIG-1:0]    trig_en,
  input  logic [NTRIG-1:0]    trig_load,
  input  logic [NTRIG-1:0]    trig_store,
  input  logic [NTRIG-1:0]    trig_select,
  input  logic [NTRIG*2-1:0]  trig_mode,
  input  logic [NTRIG*DW-1:0] trig_tdata2,
  input  logic [NTRIG-1:0]    trig_chain,
  input  logic [NTRIG*CW-1:0] trig_count,
  input  logic [NTRIG-1:0]    trig_cfg_wr,
  input  logic                lsu_valid_dc3,
  input  logic                lsu_dma_dc3,
  input  logic                lsu_load_dc3,
  input  logic                lsu_store_dc3,
  input  logic [1:0]          lsu_size_dc3,
  input  logic [DW-1:0]       lsu_addr_dc3,
  input  logic [DW-1:0]       store_data_dc3,
  input  logic                lsu_flush_dc3,
  output logic [NTRIG-1:0]    lsu_trigger_match_dc4
);

  logic [DW-1:0]             store_data_masked;
  logic [NTRIG-1:0]          raw;
  logic [NTRIG-1:0]          hit;
  logic [NTRIG-1:0]          chain_eff;
  logic [NTRIG-1:0]          gate;
  logic [NTRIG-1:0]          gated;
  logic [NTRIG-1:0]          cnt_en;
  logic [NTRIG-1:0]          arm_set;
  logic [NTRIG-1:0]          fire;
  logic [NTRIG-1:0]          armed;
  logic [NTRIG-1:0][CW-1:0]  cnt;
  logic                      qual;

  logic [DW-1:0]             operand;
  logic [DW-1:0]             td;
  logic [DW-1:0]             ign;
  logic                      prefix;
  logic                      mode_match;
  logic                      sel_ok;
  logic [CW:0]               cnt_inc;
  logic [CW:0]               thr;

  // Size-mask the store data so sub-word stores compare only their live bytes
  always_comb begin
    case (lsu_size_dc3)
      2'b00:   store_data_masked = store_data_dc3 & DW'(8'hFF);
      2'b01:   store_data_masked = store_data_dc3 & DW'(16'hFFFF);
      default: store_data_masked = store_data_dc3;
    endcase
  end

  // Per-channel raw compare; NAPOT ignores bit j when all bits below j are ones
  always_comb begin
    raw        = '0;
    operand    = '0;
    td         = '0;
    ign        = '0;
    prefix     = 1'b1;
    mode_match = 1'b0;
    sel_ok     = 1'b0;
    for (int i = 0; i < NTRIG; i++) begin
      td      = trig_tdata2[i*DW +: DW];
      operand = trig_select[i] ? store_data_masked : lsu_addr_dc3;
      sel_ok  = ~trig_select[i] | lsu_store_dc3;
      prefix  = 1'b1;
      for (int j = 0; j < DW; j++) begin
        ign[j] = prefix;
        prefix = prefix & td[j];
      end
      case (trig_mode[2*i +: 2])
        2'b00:   mode_match = (operand == td);
        2'b01:   mode_match = (((operand ^ td) & ~ign) == '0);
        2'b10:   mode_match = (operand >= td);
        default: mode_match = (operand < td);
      endcase
      raw[i] = sel_ok & mode_match;
    end
  end

  // Qualify, apply chain gating, and decide which counting channels fire
  always_comb begin
    qual      = lsu_valid_dc3 & ~lsu_dma_dc3 & ~lsu_flush_dc3;
    hit       = trig_en & {NTRIG{qual}} & raw &
                ((trig_store & {NTRIG{lsu_store_dc3}}) | (trig_load & {NTRIG{lsu_load_dc3}}));
    chain_eff = trig_chain & {1'b0, {(NTRIG-1){1'b1}}};
    gate      = {chain_eff[NTRIG-2:0], 1'b0};
    gated     = hit & (~gate | armed);
    arm_set   = {hit[NTRIG-2:0] & chain_eff[NTRIG-2:0], 1'b0};
    cnt_en    = gated & ~chain_eff;
    fire      = '0;
    cnt_inc   = '0;
    thr       = '0;
    for (int i = 0; i < NTRIG; i++) begin
      cnt_inc = {1'b0, cnt[i]} + (CW+1)'(1);
      thr     = (trig_count[i*CW +: CW] == '0) ? (CW+1)'(1) : {1'b0, trig_count[i*CW +: CW]};
      fire[i] = cnt_en[i] & (cnt_inc >= thr);
    end
  end

  // Hit counters, armed flags and the registered dc4 fire pulse
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      cnt                   <= '0;
      armed                 <= '0;
      lsu_trigger_match_dc4 <= '0;
    end else begin
      for (int i = 0; i < NTRIG; i++) begin
        if (trig_cfg_wr[i]) begin
          cnt[i]   <= '0;
          armed[i] <= 1'b0;
        end else begin
          if (cnt_en[i]) begin
            cnt[i] <= fire[i] ? '0 : cnt[i] + 1'b1;
          end
          if (arm_set[i]) begin
            armed[i] <= 1'b1;
          end else if (fire[i]) begin
            armed[i] <= 1'b0;
          end
        end
      end
      lsu_trigger_match_dc4 <= fire;
    end
  end

endmodule

// File: tb/tb_lsu_trigger_seq.sv
// Testbench for lsu_trigger_seq: directed scenarios plus randomized traffic
// checked against a behavioural model of the trigger rules.
module tb_lsu_trigger_seq;
  localparam int NTRIG = 4;
  localparam int DW    = 32;
  localparam int CW    = 4;

  logic                clk = 1'b0;
  logic                rst_l;
  logic [NTRIG-1:0]    trig_en, trig_load, trig_store, trig_select, trig_chain, trig_cfg_wr;
  logic [NTRIG*2-1:0]  trig_mode;
  logic [NTRIG*DW-1:0] trig_tdata2;
  logic [NTRIG*CW-1:0] trig_count;
  logic                lsu_valid_dc3, lsu_dma_dc3, lsu_load_dc3, lsu_store_dc3, lsu_flush_dc3;
  logic [1:0]          lsu_size_dc3;
  logic [DW-1:0]       lsu_addr_dc3, store_data_dc3;
  logic [NTRIG-1:0]    lsu_trigger_match_dc4;

  int total = 0;
  int bad   = 0;

  int m_cnt[NTRIG];
  bit m_armed[NTRIG];

  typedef struct packed {
    logic             rst;
    logic             v;
    logic             ld;
    logic             st;
    logic             dma;
    logic             fl;
    logic [1:0]       sz;
    logic [DW-1:0]    a;
    logic [DW-1:0]    d;
    logic [NTRIG-1:0] wr;
    logic [NTRIG-1:0] want;
  } row_t;

  lsu_trigger_seq #(.NTRIG(NTRIG), .DW(DW), .CW(CW)) dut (
    .clk                   (clk),
    .rst_l                 (rst_l),
    .trig_en               (trig_en),
    .trig_load             (trig_load),
    .trig_store            (trig_store),
    .trig_select           (trig_select),
    .trig_mode             (trig_mode),
    .trig_tdata2           (trig_tdata2),
    .trig_chain            (trig_chain),
    .trig_count            (trig_count),
    .trig_cfg_wr           (trig_cfg_wr),
    .lsu_valid_dc3         (lsu_valid_dc3),
    .lsu_dma_dc3           (lsu_dma_dc3),
    .lsu_load_dc3          (lsu_load_dc3),
    .lsu_store_dc3         (lsu_store_dc3),
    .lsu_size_dc3          (lsu_size_dc3),
    .lsu_addr_dc3          (lsu_addr_dc3),
    .store_data_dc3        (store_data_dc3),
    .lsu_flush_dc3         (lsu_flush_dc3),
    .lsu_trigger_match_dc4 (lsu_trigger_match_dc4)
  );

  // Free-running core clock
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  function automatic row_t mk(bit rst, bit v, bit ld, bit st, bit dma, bit fl, logic [1:0] sz,
                              logic [DW-1:0] a, logic [DW-1:0] d, logic [NTRIG-1:0] wr,
                              logic [NTRIG-1:0] want);
    row_t r;
    r.rst = rst; r.v = v; r.ld = ld; r.st = st; r.dma = dma; r.fl = fl; r.sz = sz;
    r.a = a; r.d = d; r.wr = wr; r.want = want;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lsu_valid_dc3 = 1'b0; lsu_dma_dc3 = 1'b0; lsu_load_dc3 = 1'b0; lsu_store_dc3 = 1'b0;
    lsu_flush_dc3 = 1'b0; lsu_size_dc3 = 2'b10; lsu_addr_dc3 = '0; store_data_dc3 = '0;
    trig_cfg_wr = '0;
  endtask

  task automatic clear_cfg();
    trig_en = '0; trig_load = '0; trig_store = '0; trig_select = '0; trig_chain = '0;
    trig_mode = '0; trig_tdata2 = '0; trig_count = '0; trig_cfg_wr = '0;
  endtask

  task automatic set_ch(input int i, input bit ld, input bit st, input bit sel,
                        input logic [1:0] mode, input logic [DW-1:0] td, input int count,
                        input bit chain);
    trig_en[i] = 1'b1; trig_load[i] = ld; trig_store[i] = st; trig_select[i] = sel;
    trig_mode[2*i +: 2] = mode; trig_tdata2[i*DW +: DW] = td;
    trig_count[i*CW +: CW] = CW'(count); trig_chain[i] = chain;
  endtask

  task automatic do_reset();
    idle();
    rst_l = 1'b0;
    step();
    rst_l = 1'b1;
  endtask

  task automatic drive_row(input row_t r);
    rst_l = ~r.rst; lsu_valid_dc3 = r.v; lsu_load_dc3 = r.ld; lsu_store_dc3 = r.st;
    lsu_dma_dc3 = r.dma; lsu_flush_dc3 = r.fl; lsu_size_dc3 = r.sz;
    lsu_addr_dc3 = r.a; store_data_dc3 = r.d; trig_cfg_wr = r.wr;
    step();
  endtask

  task automatic test_reset();
    clear_cfg();
    set_ch(0, 1, 0, 0, 2'b00, 32'h1000, 0, 0);
    do_reset();
    total++;
    if (lsu_trigger_match_dc4 !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_idle got=%b want=0000", lsu_trigger_match_dc4);
    end
    drive_row(mk(1, 1, 1, 0, 0, 0, 2'b10, 32'h1000, 0, 0, 4'b0000));
    total++;
    if (lsu_trigger_match_dc4 !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_with_hit got=%b want=0000", lsu_trigger_match_dc4);
    end
    rst_l = 1'b1;
    idle();
  endtask

  task automatic test_exact();
    row_t rows[$];
    clear_cfg();
    set_ch(0, 1, 0, 0, 2'b00, 32'h1000, 0, 0);
    do_reset();
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h1000, 0, 0, 4'b0001));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h1004, 0, 0, 4'b0000));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 2'b10, 32'h1000, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 0, 1, 0, 0, 2'b10, 32'h1000, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h1000, 0, 0, 4'b0001));
    foreach (rows[k]) begin
      drive_row(rows[k]);
      total++;
      if (lsu_trigger_match_dc4 !== rows[k].want) begin
        bad++; $display("[TB] FAIL exact[%0d] got=%b want=%b", k, lsu_trigger_match_dc4, rows[k].want);
      end
    end
    idle();
  endtask

  task automatic test_napot();
    row_t rows[$];
    clear_cfg();
    set_ch(1, 0, 1, 0, 2'b01, 32'h2007, 0, 0);
    do_reset();
    rows.push_back(mk(0, 1, 0, 1, 0, 0, 2'b10, 32'h200C, 0, 0, 4'b0010));
    rows.push_back(mk(0, 1, 0, 1, 0, 0, 2'b10, 32'h2010, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 0, 1, 1, 0, 2'b10, 32'h2008, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 0, 1, 0, 0, 2'b10, 32'h2000, 0, 0, 4'b0010));
    rows.push_back(mk(0, 1, 0, 1, 0, 0, 2'b10, 32'h1FFF, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h2004, 0, 0, 4'b0000));
    foreach (rows[k]) begin
      drive_row(rows[k]);
      total++;
      if (lsu_trigger_match_dc4 !== rows[k].want) begin
        bad++; $display("[TB] FAIL napot[%0d] got=%b want=%b", k, lsu_trigger_match_dc4, rows[k].want);
      end
    end
    idle();
  endtask

  task automatic test_data_select();
    row_t rows[$];
    clear_cfg();
    set_ch(2, 1, 1, 1, 2'b00, 32'h0000_00AB, 0, 0);
    do_reset();
    rows.push_back(mk(0, 1, 0, 1, 0, 0, 2'b00, 32'h5000, 32'h1234_56AB, 0, 4'b0100));
    rows.push_back(mk(0, 1, 0, 1, 0, 0, 2'b10, 32'h5000, 32'h1234_56AB, 0, 4'b0000));
    rows.push_back(mk(0, 1, 0, 1, 0, 0, 2'b01, 32'h5000, 32'h0000_12AB, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b00, 32'h0000_00AB, 32'h0000_00AB, 0, 4'b0000));
    foreach (rows[k]) begin
      drive_row(rows[k]);
      total++;
      if (lsu_trigger_match_dc4 !== rows[k].want) begin
        bad++; $display("[TB] FAIL data_sel[%0d] got=%b want=%b", k, lsu_trigger_match_dc4, rows[k].want);
      end
    end
    idle();
  endtask

  task automatic test_chain();
    row_t rows[$];
    clear_cfg();
    set_ch(0, 1, 0, 0, 2'b10, 32'h100, 0, 1);
    set_ch(1, 1, 0, 0, 2'b11, 32'h200, 0, 0);
    do_reset();
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h150, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h150, 0, 0, 4'b0010));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h150, 0, 0, 4'b0010));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h050, 0, 0, 4'b0010));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h050, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h250, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h050, 0, 0, 4'b0010));
    foreach (rows[k]) begin
      drive_row(rows[k]);
      total++;
      if (lsu_trigger_match_dc4 !== rows[k].want) begin
        bad++; $display("[TB] FAIL chain[%0d] got=%b want=%b", k, lsu_trigger_match_dc4, rows[k].want);
      end
    end
    idle();
  endtask

  task automatic test_count();
    row_t rows[$];
    clear_cfg();
    set_ch(3, 1, 0, 0, 2'b00, 32'h3000, 3, 0);
    do_reset();
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 0, 4'b1000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 0, 4'b0000));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 2'b10, 32'h0000, 0, 4'b1000, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 0, 4'b1000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 4'b1000, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 0, 4'b1000));
    foreach (rows[k]) begin
      drive_row(rows[k]);
      total++;
      if (lsu_trigger_match_dc4 !== rows[k].want) begin
        bad++; $display("[TB] FAIL count[%0d] got=%b want=%b", k, lsu_trigger_match_dc4, rows[k].want);
      end
    end
    idle();
  endtask

  task automatic test_flush();
    row_t rows[$];
    clear_cfg();
    set_ch(3, 1, 0, 0, 2'b00, 32'h3000, 2, 0);
    do_reset();
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 1, 2'b10, 32'h3000, 0, 0, 4'b0000));
    rows.push_back(mk(0, 0, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h3000, 0, 0, 4'b1000));
    rows.push_back(mk(0, 0, 0, 0, 0, 0, 2'b10, 32'h0000, 0, 0, 4'b0000));
    foreach (rows[k]) begin
      drive_row(rows[k]);
      total++;
      if (lsu_trigger_match_dc4 !== rows[k].want) begin
        bad++; $display("[TB] FAIL flush[%0d] got=%b want=%b", k, lsu_trigger_match_dc4, rows[k].want);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    clear_cfg();
    set_ch(0, 1, 0, 0, 2'b10, 32'h100, 0, 1);
    set_ch(1, 1, 0, 0, 2'b11, 32'h200, 0, 0);
    set_ch(3, 1, 0, 0, 2'b00, 32'h150, 2, 0);
    do_reset();
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h150, 0, 0, 4'b0000));
    rows.push_back(mk(1, 0, 0, 0, 0, 0, 2'b10, 32'h000, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h050, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h150, 0, 0, 4'b0000));
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 2'b10, 32'h150, 0, 0, 4'b1010));
    foreach (rows[k]) begin
      drive_row(rows[k]);
      total++;
      if (lsu_trigger_match_dc4 !== rows[k].want) begin
        bad++; $display("[TB] FAIL reset_mid[%0d] got=%b want=%b", k, lsu_trigger_match_dc4, rows[k].want);
      end
    end
    rst_l = 1'b1;
    idle();
  endtask

  function automatic bit ref_raw(logic [DW-1:0] op, logic [DW-1:0] td, logic [1:0] mode);
    int n;
    case (mode)
      2'b00: return op == td;
      2'b01: begin
        n = 0;
        while (n < DW && td[n]) n++;
        if (n == DW) return 1'b1;
        return (op >> (n + 1)) == (td >> (n + 1));
      end
      2'b10: return op >= td;
      default: return op < td;
    endcase
  endfunction

  task automatic test_random();
    logic [NTRIG-1:0] want;
    logic [DW-1:0]    op, td, dm;
    bit               h[NTRIG];
    bit               fired[NTRIG];
    bit               set_arm[NTRIG];
    int               n_cnt[NTRIG];
    int               thr, j;
    clear_cfg();
    do_reset();
    for (int i = 0; i < NTRIG; i++) begin m_cnt[i] = 0; m_armed[i] = 0; end
    for (int ph = 0; ph < 8; ph++) begin
      clear_cfg();
      for (int i = 0; i < NTRIG; i++) begin
        if ($urandom_range(0, 4) != 0) begin
          td = (DW'($urandom_range(1, 7)) << 8) | DW'($urandom_range(0, 255));
          if ($urandom_range(0, 3) == 0) td = DW'($urandom_range(0, 255));
          if ($urandom_range(0, 15) == 0) td = '1;
          set_ch(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), td,
                 $urandom_range(0, 3), 1'($urandom_range(0, 2) == 0));
          if (!trig_load[i] && !trig_store[i]) trig_load[i] = 1'b1;
        end
      end
      for (int c = 0; c < 100; c++) begin
        idle();
        rst_l = ($urandom_range(0, 49) != 0);
        lsu_valid_dc3 = ($urandom_range(0, 4) != 0);
        lsu_dma_dc3   = ($urandom_range(0, 9) == 0);
        lsu_flush_dc3 = ($urandom_range(0, 9) == 0);
        lsu_load_dc3  = 1'($urandom_range(0, 1));
        lsu_store_dc3 = ~lsu_load_dc3;
        lsu_size_dc3  = 2'($urandom_range(0, 2));
        j = $urandom_range(0, NTRIG - 1);
        if ($urandom_range(0, 1) == 0)
          lsu_addr_dc3 = trig_tdata2[j*DW +: DW] + DW'($urandom_range(0, 16)) - DW'(8);
        else
          lsu_addr_dc3 = DW'($urandom_range(0, 32'h7FF));
        store_data_dc3 = {DW'($urandom)} << 8 | DW'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 0) store_data_dc3 = trig_tdata2[j*DW +: DW];
        if (!lsu_valid_dc3) trig_cfg_wr = NTRIG'($urandom_range(0, 15)) & NTRIG'($urandom_range(0, 15));

        want = '0;
        if (!rst_l) begin
          for (int i = 0; i < NTRIG; i++) begin n_cnt[i] = 0; set_arm[i] = 0; fired[i] = 0; end
        end else begin
          dm = (lsu_size_dc3 == 2'b00) ? (store_data_dc3 & 32'hFF) :
               (lsu_size_dc3 == 2'b01) ? (store_data_dc3 & 32'hFFFF) : store_data_dc3;
          for (int i = 0; i < NTRIG; i++) begin
            op = trig_select[i] ? dm : lsu_addr_dc3;
            h[i] = lsu_valid_dc3 && !lsu_dma_dc3 && !lsu_flush_dc3 && trig_en[i] &&
                   ((trig_store[i] && lsu_store_dc3) || (trig_load[i] && lsu_load_dc3)) &&
                   (!trig_select[i] || lsu_store_dc3) &&
                   ref_raw(op, trig_tdata2[i*DW +: DW], trig_mode[2*i +: 2]);
            n_cnt[i] = m_cnt[i]; set_arm[i] = 0; fired[i] = 0;
          end
          for (int i = 0; i < NTRIG; i++) begin
            if (i < NTRIG - 1 && trig_chain[i]) begin
              if (h[i]) set_arm[i+1] = 1;
            end else if (h[i] && (i == 0 || !trig_chain[i-1] || m_armed[i])) begin
              thr = (trig_count[i*CW +: CW] == 0) ? 1 : int'(trig_count[i*CW +: CW]);
              if (m_cnt[i] + 1 >= thr) begin
                want[i] = 1'b1; fired[i] = 1; n_cnt[i] = 0;
              end else begin
                n_cnt[i] = m_cnt[i] + 1;
              end
            end
          end
        end

        step();
        total++;
        if (lsu_trigger_match_dc4 !== want) begin
          bad++;
          $display("[TB] FAIL random[ph%0d c%0d] got=%b want=%b", ph, c, lsu_trigger_match_dc4, want);
        end

        for (int i = 0; i < NTRIG; i++) begin
          if (!rst_l || trig_cfg_wr[i]) begin
            m_cnt[i] = 0; m_armed[i] = 0;
          end else begin
            m_cnt[i] = n_cnt[i];
            if (set_arm[i]) m_armed[i] = 1;
            else if (fired[i]) m_armed[i] = 0;
          end
        end
      end
    end
    rst_l = 1'b1;
    idle();
  endtask

  // Run all scenarios in sequence and report
  initial begin
    rst_l = 1'b0;
    clear_cfg();
    idle();
    test_reset();
    test_exact();
    test_napot();
    test_data_select();
    test_chain();
    test_count();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
